// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
//   Shares one APB master port between four requesters with round-robin
//   arbitration. Each transfer runs SETUP then ACCESS, honours Pready wait
//   states, and is aborted with an error after TIMEOUT consecutive wait
//   cycles so a dead slave cannot lock the bus.
//
// Ports
//   HCLK, HRESET       clock (rising edge), async active-high reset
//   Req[3:0]           per-requester request, held until its Done
//   Rwrite[3:0]        per-requester direction (1 = write)
//   Raddr/Rwdata       4 x 32-bit packed, requester i at [32i+31:32i]
//   Gnt[3:0]           one-hot owner, SETUP through end of ACCESS
//   Done[3:0]          one-hot single-cycle completion pulse
//   Err, Rdata         completion status / read data, valid with Done
//   Psel..Pwdata       APB master outputs (all registered)
//   Prdata, Pready, Pslverr  APB slave responses
module apb_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic [3:0]   Req,
  input  logic [3:0]   Rwrite,
  input  logic [127:0] Raddr,
  input  logic [127:0] Rwdata,
  output logic [3:0]   Gnt,
  output logic [3:0]   Done,
  output logic         Err,
  output logic [31:0]  Rdata,
  output logic         Psel,
  output logic         Penable,
  output logic         Pwrite,
  output logic [31:0]  Paddr,
  output logic [31:0]  Pwdata,
  input  logic [31:0]  Prdata,
  input  logic         Pready,
  input  logic         Pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  // Last grant. It is only updated on a grant, so during a transfer it is
  // also the index of the current owner.
  logic [1:0]  ptr, ptr_nxt;
  logic [7:0]  wcnt, wcnt_nxt;

  logic [3:0]  gnt_nxt, done_nxt;
  logic        err_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  logic [31:0] rdata_nxt, paddr_nxt, pwdata_nxt;

  logic [3:0]  elig;
  logic        win_vld;
  logic [1:0]  win_idx;

  // First set bit of mask searching upward from last+1, wrapping mod 4.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    // Walk the distances from farthest to nearest so the nearest hit wins.
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (mask[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // A requester whose Done is showing may still hold Req this cycle; it must
  // not be regranted on that stale request.
  always_comb begin
    elig               = Req & ~Done;
    {win_vld, win_idx} = rr_pick(elig, ptr);
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    wcnt_nxt    = wcnt;
    gnt_nxt     = Gnt;
    done_nxt    = 4'b0000;
    err_nxt     = 1'b0;
    rdata_nxt   = Rdata;
    psel_nxt    = Psel;
    penable_nxt = Penable;
    pwrite_nxt  = Pwrite;
    paddr_nxt   = Paddr;
    pwdata_nxt  = Pwdata;

    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          paddr_nxt   = Raddr[{win_idx, 5'd0} +: 32];
          pwdata_nxt  = Rwdata[{win_idx, 5'd0} +: 32];
          pwrite_nxt  = Rwrite[win_idx];
          gnt_nxt     = 4'b0001 << win_idx;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          ptr_nxt     = win_idx;
          state_nxt   = ST_SETUP;
        end else begin
          psel_nxt = 1'b0;
          gnt_nxt  = 4'b0000;
        end
      end

      ST_SETUP: begin
        penable_nxt = 1'b1;
        wcnt_nxt    = 8'd0;
        state_nxt   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (Pready) begin
          done_nxt    = 4'b0001 << ptr;
          err_nxt     = Pslverr;
          rdata_nxt   = Pwrite ? 32'd0 : Prdata;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          gnt_nxt     = 4'b0000;
          state_nxt   = ST_IDLE;
        end else if (wcnt == WCNT_LAST) begin
          // Slave never answered: abort with an error and no data.
          done_nxt    = 4'b0001 << ptr;
          err_nxt     = 1'b1;
          rdata_nxt   = 32'd0;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          gnt_nxt     = 4'b0000;
          state_nxt   = ST_IDLE;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered control and APB outputs
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ptr     <= 2'd3;
      wcnt    <= 8'd0;
      Gnt     <= 4'b0000;
      Done    <= 4'b0000;
      Err     <= 1'b0;
      Rdata   <= 32'd0;
      Psel    <= 1'b0;
      Penable <= 1'b0;
      Pwrite  <= 1'b0;
      Paddr   <= 32'd0;
      Pwdata  <= 32'd0;
    end else begin
      ptr     <= ptr_nxt;
      wcnt    <= wcnt_nxt;
      Gnt     <= gnt_nxt;
      Done    <= done_nxt;
      Err     <= err_nxt;
      Rdata   <= rdata_nxt;
      Psel    <= psel_nxt;
      Penable <= penable_nxt;
      Pwrite  <= pwrite_nxt;
      Paddr   <= paddr_nxt;
      Pwdata  <= pwdata_nxt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      assert (NREQ == 4 && TIMEOUT >= 1 && TIMEOUT <= 255)
        else $error("apb_rr_arbiter: illegal NREQ/TIMEOUT");
      assert ($onehot0(Gnt) && $onehot0(Done))
        else $error("apb_rr_arbiter: Gnt/Done not one-hot");
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
module tb_apb_rr_arbiter;

  localparam int T = 4;

  logic         HCLK = 1'b0;
  logic         HRESET = 1'b1;
  logic [3:0]   Req = '0;
  logic [3:0]   Rwrite = '0;
  logic [127:0] Raddr = '0;
  logic [127:0] Rwdata = '0;
  logic [3:0]   Gnt;
  logic [3:0]   Done;
  logic         Err;
  logic [31:0]  Rdata;
  logic         Psel;
  logic         Penable;
  logic         Pwrite;
  logic [31:0]  Paddr;
  logic [31:0]  Pwdata;
  logic [31:0]  Prdata = '0;
  logic         Pready = 1'b0;
  logic         Pslverr = 1'b0;

  apb_rr_arbiter #(.NREQ(4), .TIMEOUT(T)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .Req(Req), .Rwrite(Rwrite),
    .Raddr(Raddr), .Rwdata(Rwdata), .Gnt(Gnt), .Done(Done), .Err(Err),
    .Rdata(Rdata), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready),
    .Pslverr(Pslverr)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Requester jobs
  bit          act[4];
  bit          jwr[4];
  logic [31:0] jaddr[4];
  logic [31:0] jdata[4];
  int          done_cyc[4];

  // Transaction-level reference: cycle numbers of grant and completion
  int          cyc;
  int          ptr;
  bit          busy;
  int          g, d, win, waits;
  bit          rerr, derr;
  logic [31:0] rrd, drd, rd_hold;
  bit          xwr;
  logic [31:0] xaddr, xdata;

  // Stimulus controls
  int          mode;        // 0 none, 1 random, 2 continuous on cont_mask
  logic [3:0]  cont_mask;
  int          start_pct;
  int          force_n;
  int          f_waits;
  bit          f_err;
  logic [31:0] f_rd;

  // Observations
  int          gq[$];
  int          pq[$];
  int          dq[$];
  int          eq[$];
  logic [31:0] rq[$];
  bit          prev_psel;

  task automatic start_job(input int i, input bit wr, input logic [31:0] a, input logic [31:0] dt);
    act[i] = 1'b1; jwr[i] = wr; jaddr[i] = a; jdata[i] = dt;
  endtask

  task automatic check_cycle();
    logic [3:0] eg, ed;
    logic       ep, en, ee;
    int         c, gi;
    c = cyc; ep = 0; en = 0; eg = 0; ed = 0; ee = 0;
    if (busy) begin
      ep = (c > g) && (c < d);
      en = (c > g + 1) && (c < d);
      if (ep) eg = 4'b0001 << win;
      if (c == d) begin
        ed = 4'b0001 << win; ee = derr; rd_hold = drd;
      end
    end
    chk("Psel", Psel, ep);
    chk("Penable", Penable, en);
    chk("Gnt", Gnt, eg);
    chk("Done", Done, ed);
    chk("Err", Err, ee);
    chk("Rdata", Rdata, rd_hold);
    if (ep) begin
      chk("Paddr", Paddr, xaddr);
      chk("Pwdata", Pwdata, xdata);
      chk("Pwrite", Pwrite, xwr);
    end
    if (Psel && !prev_psel) begin
      gi = -1;
      for (int i = 0; i < 4; i++) if (Gnt == (4'b0001 << i)) gi = i;
      gq.push_back(gi);
      pq.push_back(c);
    end
    if (Done != 4'b0000) begin
      dq.push_back(c); eq.push_back(int'(Err)); rq.push_back(Rdata);
    end
    prev_psel = Psel;
    if (busy && c == d) begin
      busy = 0; act[win] = 0; done_cyc[win] = c;
    end
  endtask

  task automatic drive_cycle();
    logic [3:0] rqv, dm, mask;
    int         c, j;
    bit         st;
    c = cyc; rqv = 0; dm = 0;
    for (int i = 0; i < 4; i++) begin
      if ((busy && win == i) || done_cyc[i] == c) begin
        // Owner after grant or in its Done cycle: Req and data are don't-care.
        rqv[i] = 1'($urandom_range(0, 1));
        Rwrite[i] = 1'($urandom_range(0, 1));
        Raddr[i*32 +: 32] = $urandom;
        Rwdata[i*32 +: 32] = $urandom;
        if (done_cyc[i] == c) dm[i] = 1'b1;
      end else begin
        st = 0;
        if (mode == 1) st = ($urandom_range(0, 99) < start_pct);
        if (mode == 2) st = cont_mask[i];
        if (!act[i] && st) start_job(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        if (act[i]) begin
          rqv[i] = 1'b1;
          Rwrite[i] = jwr[i];
          Raddr[i*32 +: 32] = jaddr[i];
          Rwdata[i*32 +: 32] = jdata[i];
        end else begin
          Rwrite[i] = 1'($urandom_range(0, 1));
          Raddr[i*32 +: 32] = $urandom;
          Rwdata[i*32 +: 32] = $urandom;
        end
      end
    end
    Req = rqv;
    mask = rqv & ~dm;
    if (!busy && mask != 4'b0000) begin
      j = -1;
      for (int k = 1; k <= 4; k++)
        if (j < 0 && mask[(ptr + k) % 4]) j = (ptr + k) % 4;
      win = j; ptr = j; busy = 1; g = c;
      xwr = jwr[j]; xaddr = jaddr[j]; xdata = jdata[j];
      if (force_n > 0) begin
        force_n--; waits = f_waits; rerr = f_err; rrd = f_rd;
      end else begin
        waits = $urandom_range(0, 5); rerr = ($urandom_range(0, 3) == 0); rrd = $urandom;
      end
      if (waits < T) begin
        d = g + 3 + waits; derr = rerr; drd = xwr ? 32'd0 : rrd;
      end else begin
        d = g + 2 + T; derr = 1; drd = 32'd0;
      end
    end
    if (busy && c >= g + 2 && c < d) begin
      if (waits < T && (c - g - 2) == waits) begin
        Pready = 1'b1; Prdata = rrd; Pslverr = rerr;
      end else begin
        Pready = 1'b0; Prdata = $urandom; Pslverr = 1'($urandom_range(0, 1));
      end
    end else begin
      Pready = 1'($urandom_range(0, 1)); Prdata = $urandom; Pslverr = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step();
    @(posedge HCLK); #1;
    cyc++;
    check_cycle();
    drive_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int limit);
    int  k;
    bit  pend;
    mode = 0; k = 0;
    pend = busy || act[0] || act[1] || act[2] || act[3];
    while (pend && k < limit) begin
      step(); k++;
      pend = busy || act[0] || act[1] || act[2] || act[3];
    end
    chk("drain_bound", pend, 0);
  endtask

  task automatic clear_obs();
    gq.delete(); pq.delete(); dq.delete(); eq.delete(); rq.delete();
  endtask

  task automatic do_reset();
    HRESET = 1'b1; Req = '0; Pready = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_Psel", Psel, 0);
    chk("rst_Penable", Penable, 0);
    chk("rst_Pwrite", Pwrite, 0);
    chk("rst_Gnt", Gnt, 0);
    chk("rst_Done", Done, 0);
    chk("rst_Err", Err, 0);
    chk("rst_Paddr", Paddr, 0);
    chk("rst_Pwdata", Pwdata, 0);
    chk("rst_Rdata", Rdata, 0);
    HRESET = 1'b0;
    cyc = 0; ptr = 3; busy = 0; rd_hold = 0; prev_psel = 0;
    mode = 0; force_n = 0;
    for (int i = 0; i < 4; i++) begin act[i] = 0; done_cyc[i] = -10; end
    clear_obs();
    drive_cycle();
  endtask

  initial begin
    int k;

    // Single read from requester 2, zero wait states
    do_reset();
    start_job(2, 0, 32'h1000_0040, 32'h0);
    force_n = 1; f_waits = 0; f_err = 0; f_rd = 32'hDEAD_BEEF;
    drain(50);
    chk("A_gnt", (gq.size() > 0) ? gq[0] : -1, 2);
    chk("A_lat", (dq.size() > 0 && pq.size() > 0) ? dq[0] - pq[0] : -1, 2);
    chk("A_rdata", Rdata, 32'hDEAD_BEEF);

    // Four simultaneous writes out of reset
    do_reset();
    for (int i = 0; i < 4; i++) start_job(i, 1, $urandom, $urandom);
    force_n = 4; f_waits = 0; f_err = 0; f_rd = 32'h0;
    drain(100);
    chk("B_cnt", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++) chk("B_order", gq[i], i);
    for (int i = 1; i < dq.size(); i++) chk("B_gap", dq[i] - dq[i-1], 3);

    // Three wait states then error
    clear_obs();
    start_job(1, 0, $urandom, $urandom);
    force_n = 1; f_waits = 3; f_err = 1; f_rd = $urandom;
    drain(50);
    chk("C_lat", (dq.size() > 0 && pq.size() > 0) ? dq[0] - pq[0] : -1, 5);
    chk("C_err", (eq.size() > 0) ? eq[0] : -1, 1);

    // Timeout followed by another requester
    clear_obs();
    start_job(0, 0, $urandom, $urandom);
    start_job(3, 1, $urandom, $urandom);
    force_n = 1; f_waits = 99; f_err = 0; f_rd = 32'h1234_5678;
    drain(80);
    chk("D_lat", (dq.size() > 0 && pq.size() > 0) ? dq[0] - pq[0] : -1, 1 + T);
    chk("D_err", (eq.size() > 0) ? eq[0] : -1, 1);
    chk("D_rdata", (rq.size() > 0) ? rq[0] : 32'hFFFF_FFFF, 32'h0);
    chk("D_next", gq.size(), 2);

    // Fairness with requesters 1 and 3 always pending
    do_reset();
    mode = 2; cont_mask = 4'b1010;
    run(60);
    drain(100);
    chk("E_first", (gq.size() > 0) ? gq[0] : -1, 1);
    for (int i = 1; i < gq.size(); i++) chk("E_alt", gq[i], (gq[i-1] == 1) ? 3 : 1);

    // Random traffic
    do_reset();
    mode = 1; start_pct = 25;
    run(1500);
    drain(200);

    // Reset while in ACCESS
    for (int i = 0; i < 4; i++) start_job(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    force_n = 1; f_waits = 3; f_err = 0; f_rd = $urandom;
    k = 0;
    while (!Penable && k < 20) begin step(); k++; end
    chk("G_reach_access", Penable, 1);
    #2;
    HRESET = 1'b1;
    #1;
    chk("G_Psel", Psel, 0);
    chk("G_Penable", Penable, 0);
    chk("G_Gnt", Gnt, 0);
    chk("G_Done", Done, 0);
    do_reset();
    for (int i = 0; i < 4; i++) start_job(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    drain(100);
    chk("G_cnt", gq.size(), 4);
    chk("G_first", (gq.size() > 0) ? gq[0] : -1, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
